// File: rtl/awg_desc_unpacker.sv
// Descriptor unpacker: turns 4-beat AXI-stream frames into parallel descriptor
// fields and queues them in a small FIFO for the playback sequencer.
module awg_desc_unpacker #(
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_AW    = 2,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stop,
   input  logic [31:0]         axis_data,
   input  logic                axis_valid,
   input  logic                axis_last,
   output logic                axis_ready,
   output logic                desc_valid,
   input  logic                desc_ready,
   output logic [7:0]          desc_opcode,
   output logic [7:0]          desc_channel,
   output logic [15:0]         desc_repeat,
   output logic [31:0]         desc_addr,
   output logic [31:0]         desc_len,
   output logic [31:0]         desc_delay,
   output logic [FIFO_AW:0]    fifo_level,
   output logic                err_short,
   output logic                err_long,
   output logic [CNT_W-1:0]    good_count,
   output logic [CNT_W-1:0]    err_count
);

   typedef enum logic {COLLECT, DISCARD} state_t;

   localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

   state_t             state_reg;
   logic [1:0]         idx_reg;
   logic [31:0]        word_reg [3];
   logic [127:0]       mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_reg;
   logic [FIFO_AW-1:0] rd_ptr_reg;
   logic [FIFO_AW:0]   level_reg;
   logic [FIFO_AW:0]   level_next;
   logic               ready_reg;
   logic               err_short_reg;
   logic               err_long_reg;
   logic [CNT_W-1:0]   good_count_reg;
   logic [CNT_W-1:0]   err_count_reg;
   logic               beat_acc;
   logic               collect_beat;
   logic               push;
   logic               pop;
   logic               short_drop;
   logic               long_drop;
   logic               discard_next;
   logic [127:0]       head;

   // stop masks the handshake in its own cycle, so no beat can be stored then
   assign axis_ready   = ready_reg & ~stop;
   assign beat_acc     = axis_valid & axis_ready;
   assign collect_beat = beat_acc && (state_reg == COLLECT);
   assign push         = collect_beat && axis_last && (idx_reg == 2'd3);
   assign short_drop   = collect_beat && axis_last && (idx_reg != 2'd3);
   assign long_drop    = collect_beat && !axis_last && (idx_reg == 2'd3);
   assign desc_valid   = (level_reg != '0);
   assign pop          = desc_valid & desc_ready;

   always_comb begin
      level_next = level_reg;
      if (stop)
         level_next = '0;
      else if (push && !pop)
         level_next = level_reg + 1'b1;
      else if (pop && !push)
         level_next = level_reg - 1'b1;
   end

   always_comb begin
      discard_next = 1'b0;
      if (!stop) begin
         if (state_reg == DISCARD)
            discard_next = !(beat_acc && axis_last);
         else
            discard_next = long_drop;
      end
   end

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_word
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               word_reg[gi] <= '0;
            else if (collect_beat && (idx_reg == 2'(gi)))
               word_reg[gi] <= axis_data;
         end
      end
   endgenerate

   // Word 3 is taken straight from the bus on the final beat.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= {word_reg[0], word_reg[1], word_reg[2], axis_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= COLLECT;
         idx_reg        <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         level_reg      <= '0;
         ready_reg      <= 1'b0;
         err_short_reg  <= 1'b0;
         err_long_reg   <= 1'b0;
         good_count_reg <= '0;
         err_count_reg  <= '0;
      end else begin
         level_reg     <= level_next;
         ready_reg     <= discard_next || (level_next != LEVEL_FULL);
         state_reg     <= discard_next ? DISCARD : COLLECT;
         err_short_reg <= short_drop;
         err_long_reg  <= long_drop;
         if (stop) begin
            idx_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (collect_beat)
               idx_reg <= (axis_last || idx_reg == 2'd3) ? 2'd0 : idx_reg + 1'b1;
            if (push)
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (push && good_count_reg != '1)
            good_count_reg <= good_count_reg + 1'b1;
         if ((short_drop || long_drop) && err_count_reg != '1)
            err_count_reg <= err_count_reg + 1'b1;
      end
   end

   // Fields read as zero when empty so the outputs are clean out of reset.
   assign head         = desc_valid ? mem[rd_ptr_reg] : '0;
   assign desc_opcode  = head[127:120];
   assign desc_channel = head[119:112];
   assign desc_repeat  = head[111:96];
   assign desc_addr    = head[95:64];
   assign desc_len     = head[63:32];
   assign desc_delay   = head[31:0];
   assign fifo_level   = level_reg;
   assign err_short    = err_short_reg;
   assign err_long     = err_long_reg;
   assign good_count   = good_count_reg;
   assign err_count    = err_count_reg;

endmodule
